// File: rtl/control_ventana_pkg.sv
// Shared definitions for the multichannel window-control block:
// register offsets, control/status bit positions and sequencer states.
package control_ventana_pkg;

  localparam logic [2:0] OFS_INICIO_IMAGEN = 3'd0;
  localparam logic [2:0] OFS_CANT_LECTURAS = 3'd1;
  localparam logic [2:0] OFS_BUFFERS       = 3'd2;
  localparam logic [2:0] OFS_CONTROL       = 3'd3;
  localparam logic [2:0] OFS_ESTADO        = 3'd4;

  localparam int BIT_INICIO    = 0;
  localparam int BIT_ABORTAR   = 1;

  localparam int BIT_OCUPADO   = 0;
  localparam int BIT_ERROR     = 1;
  localparam int BIT_CANAL_LSB = 2;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    LECTURA = 2'd1,
    FIN     = 2'd2
  } estado_t;

endpackage

// File: rtl/generador_direcciones_ventana.sv
// Read-address sequencer: latches one channel's window configuration on
// inicio and issues consecutive memory addresses under valid/ready.
module generador_direcciones_ventana
  import control_ventana_pkg::*;
#(
  parameter int BITS_DIRECCION_MEM = 10,
  parameter int BITS_BUFFERS       = 3,
  parameter int BITS_CANAL         = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inicio,
  input  logic                          abortar,
  input  logic [BITS_CANAL-1:0]         canal,
  input  logic [BITS_DIRECCION_MEM-1:0] direccion_inicio,
  input  logic [BITS_DIRECCION_MEM-1:0] cantidad,
  input  logic [BITS_BUFFERS-1:0]       buffers,
  input  logic                          acepta_lectura,
  output logic [BITS_DIRECCION_MEM-1:0] direccion_mem,
  output logic                          solicitud_lectura,
  output logic [BITS_CANAL-1:0]         canal_activo,
  output logic [BITS_BUFFERS-1:0]       cantidad_buffers_activos,
  output logic                          ocupado,
  output logic                          fin_lectura,
  output logic                          inicio_ignorado
);

  localparam logic [BITS_DIRECCION_MEM-1:0] UNO = BITS_DIRECCION_MEM'(1);

  estado_t                       estado;
  estado_t                       estado_sig;
  logic [BITS_DIRECCION_MEM-1:0] restantes;
  logic                          arranque;
  logic                          acepta;

  // abortar in the same control write cancels the start request
  assign arranque        = inicio && !abortar;
  assign acepta          = (estado == LECTURA) && acepta_lectura;
  assign inicio_ignorado = arranque && (estado != REPOSO);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  // Next-state logic; abort takes priority over the final accept
  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO: begin
        if (arranque) estado_sig = (cantidad == '0) ? FIN : LECTURA;
      end
      LECTURA: begin
        if (abortar)                       estado_sig = REPOSO;
        else if (acepta && restantes == UNO) estado_sig = FIN;
      end
      FIN:     estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    solicitud_lectura = 1'b0;
    ocupado           = 1'b0;
    fin_lectura       = 1'b0;
    case (estado)
      LECTURA: begin
        solicitud_lectura = 1'b1;
        ocupado           = 1'b1;
      end
      FIN: begin
        ocupado     = 1'b1;
        fin_lectura = 1'b1;
      end
      default: ;
    endcase
  end

  // Latched burst copies plus address/remaining counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      direccion_mem            <= '0;
      restantes                <= '0;
      canal_activo             <= '0;
      cantidad_buffers_activos <= '0;
    end else if (estado == REPOSO && arranque) begin
      direccion_mem            <= direccion_inicio;
      restantes                <= cantidad;
      canal_activo             <= canal;
      cantidad_buffers_activos <= buffers;
    end else if (acepta) begin
      direccion_mem <= direccion_mem + UNO;
      restantes     <= restantes - UNO;
    end
  end

endmodule

// File: rtl/control_ventana_multicanal.sv
// Multichannel window-control register block with read-address sequencer.
// Optional readback/status path enabled by CONTROL_VENTANA_LECTURA_EN.
module control_ventana_multicanal
  import control_ventana_pkg::*;
#(
  parameter int BITS_BUS_DATOS_INSTR     = 24,
  parameter int BITS_BUS_DIRECCION_INSTR = 8,
  parameter int BITS_DIRECCION_MEM       = 10,
  parameter int BITS_BUFFERS             = 3,
  parameter int CANALES                  = 2,
  localparam int BITS_CANAL = (CANALES > 1) ? $clog2(CANALES) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [BITS_BUS_DIRECCION_INSTR-1:0] direccion_registros,
  input  logic [BITS_BUS_DATOS_INSTR-1:0]     datos_registros,
  input  logic                                habilitacion_registros,
  input  logic                                lectura_registros,
  output logic [BITS_BUS_DATOS_INSTR-1:0]     datos_lectura,
  output logic [BITS_DIRECCION_MEM-1:0]       direccion_mem,
  output logic                                solicitud_lectura,
  input  logic                                acepta_lectura,
  output logic [BITS_CANAL-1:0]               canal_activo,
  output logic [BITS_BUFFERS-1:0]             cantidad_buffers_activos,
  output logic                                ocupado,
  output logic                                fin_lectura
);

  logic [BITS_DIRECCION_MEM-1:0] inicio_imagen [CANALES];
  logic [BITS_DIRECCION_MEM-1:0] cant_lecturas [CANALES];
  logic [BITS_BUFFERS-1:0]       buffers       [CANALES];

  logic [2:0]            offset;
  logic [BITS_CANAL-1:0] canal;
  logic                  canal_valido;
  logic [BITS_CANAL-1:0] canal_idx;
  logic                  escritura;
  logic                  escritura_control;
  logic                  inicio_q;
  logic                  abortar_q;
  logic [BITS_CANAL-1:0] canal_q;
  logic                  inicio_ignorado;
  logic                  error;
  logic                  bits_unused;

  assign offset            = direccion_registros[2:0];
  assign canal             = direccion_registros[3 +: BITS_CANAL];
  assign canal_valido      = int'(canal) < CANALES;
  assign canal_idx         = canal_valido ? canal : '0;
  assign escritura         = habilitacion_registros && canal_valido;
  assign escritura_control = escritura && (offset == OFS_CONTROL);

  // Per-channel configuration registers, writable at any time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CANALES; i++) begin
        inicio_imagen[i] <= '0;
        cant_lecturas[i] <= '0;
        buffers[i]       <= '0;
      end
    end else if (escritura) begin
      case (offset)
        OFS_INICIO_IMAGEN: inicio_imagen[canal_idx] <= datos_registros[BITS_DIRECCION_MEM-1:0];
        OFS_CANT_LECTURAS: cant_lecturas[canal_idx] <= datos_registros[BITS_DIRECCION_MEM-1:0];
        OFS_BUFFERS:       buffers[canal_idx]       <= datos_registros[BITS_BUFFERS-1:0];
        default: ;
      endcase
    end
  end

  // Control writes become one-cycle pulses so the sequencer sees settled config
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inicio_q  <= 1'b0;
      abortar_q <= 1'b0;
      canal_q   <= '0;
    end else begin
      inicio_q  <= escritura_control && datos_registros[BIT_INICIO];
      abortar_q <= escritura_control && datos_registros[BIT_ABORTAR];
      canal_q   <= canal_idx;
    end
  end

  // Sticky error flag; a new ignored start beats a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      error <= 1'b0;
    else if (inicio_ignorado)
      error <= 1'b1;
    else if (escritura && offset == OFS_ESTADO && datos_registros[BIT_ERROR])
      error <= 1'b0;
  end

  generador_direcciones_ventana #(
    .BITS_DIRECCION_MEM (BITS_DIRECCION_MEM),
    .BITS_BUFFERS       (BITS_BUFFERS),
    .BITS_CANAL         (BITS_CANAL)
  ) u_generador (
    .clk                      (clk),
    .reset                    (reset),
    .inicio                   (inicio_q),
    .abortar                  (abortar_q),
    .canal                    (canal_q),
    .direccion_inicio         (inicio_imagen[canal_q]),
    .cantidad                 (cant_lecturas[canal_q]),
    .buffers                  (buffers[canal_q]),
    .acepta_lectura           (acepta_lectura),
    .direccion_mem            (direccion_mem),
    .solicitud_lectura        (solicitud_lectura),
    .canal_activo             (canal_activo),
    .cantidad_buffers_activos (cantidad_buffers_activos),
    .ocupado                  (ocupado),
    .fin_lectura              (fin_lectura),
    .inicio_ignorado          (inicio_ignorado)
  );

`ifdef CONTROL_VENTANA_LECTURA_EN
  logic [BITS_BUS_DATOS_INSTR-1:0] valor_lectura;

  // Readback mux; control and unused offsets read as zero
  always_comb begin
    valor_lectura = '0;
    if (canal_valido) begin
      case (offset)
        OFS_INICIO_IMAGEN: valor_lectura[BITS_DIRECCION_MEM-1:0] = inicio_imagen[canal_idx];
        OFS_CANT_LECTURAS: valor_lectura[BITS_DIRECCION_MEM-1:0] = cant_lecturas[canal_idx];
        OFS_BUFFERS:       valor_lectura[BITS_BUFFERS-1:0]       = buffers[canal_idx];
        OFS_ESTADO: begin
          valor_lectura[BIT_OCUPADO]                = ocupado;
          valor_lectura[BIT_ERROR]                  = error;
          valor_lectura[BIT_CANAL_LSB +: BITS_CANAL] = canal_activo;
        end
        default: ;
      endcase
    end
  end

  // Registered readback, held between read strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 datos_lectura <= '0;
    else if (lectura_registros) datos_lectura <= valor_lectura;
  end

  assign bits_unused = ^{datos_registros, direccion_registros};
`else
  assign datos_lectura = '0;
  assign bits_unused   = ^{datos_registros, direccion_registros, lectura_registros, error};
`endif

endmodule
